regfile_wr_arbiter: RTL and testbench

- Shares the single register-file write port (we3/a3/wd3) between two writeback requesters: req0 is the ALU/execute result and req1 is the load/memory result.
- Uses round-robin arbitration with a valid/ready handshake.
- Registers the granted write into a one-entry write stage that drives the register file.
- Forwards the in-flight write onto both read ports so readers never see stale data.

---
 rtl/regfile_wr_arbiter.sv | 84 ++++++++
 tb/tb_regfile_wr_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and
// load writeback paths, with a registered write stage and read-port forwarding.
module regfile_wr_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              we3,
   output logic [ADDR_W-1:0] a3,
   output logic [DATA_W-1:0] wd3,
   input  logic [ADDR_W-1:0] a1,
   input  logic [ADDR_W-1:0] a2,
   input  logic [DATA_W-1:0] rf_rd1,
   input  logic [DATA_W-1:0] rf_rd2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              conflict
);

   typedef enum logic {PREF_REQ0, PREF_REQ1} ptr_t;

   ptr_t ptr, ptr_nxt;

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      conflict   = 1'b0;
      ptr_nxt    = ptr;
      if (rst && !hold) begin
         if (req0_valid && req1_valid) begin
            conflict = 1'b1;
            if (ptr == PREF_REQ0) req0_ready = 1'b1;
            else                  req1_ready = 1'b1;
         end else begin
            req0_ready = req0_valid;
            req1_ready = req1_valid;
         end
      end
      // The requester that just transferred drops to lowest priority.
      if (req0_ready)      ptr_nxt = PREF_REQ1;
      else if (req1_ready) ptr_nxt = PREF_REQ0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr <= PREF_REQ0;
         we3 <= 1'b0;
         a3  <= '0;
         wd3 <= '0;
      end else begin
         ptr <= ptr_nxt;
         if (req0_ready) begin
            we3 <= (req0_addr != '0);
            a3  <= req0_addr;
            wd3 <= req0_data;
         end else if (req1_ready) begin
            we3 <= (req1_addr != '0);
            a3  <= req1_addr;
            wd3 <= req1_data;
         end else begin
            we3 <= 1'b0;
         end
      end
   end

   // x0 never forwards so the register file's hardwired zero shows through.
   always_comb begin
      rd1 = rf_rd1;
      rd2 = rf_rd2;
      if (we3 && (a3 == a1) && (a1 != '0)) rd1 = wd3;
      if (we3 && (a3 == a2) && (a2 != '0)) rd2 = wd3;
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with hand-computed expectations.
module tb_regfile_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst, hold;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [4:0]  req0_addr, req1_addr, a3, a1, a2;
   logic [31:0] req0_data, req1_data, wd3, rf_rd1, rf_rd2, rd1, rd2;
   logic        we3, conflict;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   regfile_wr_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .hold(hold),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .we3(we3), .a3(a3), .wd3(wd3), .a1(a1), .a2(a2),
      .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .rd1(rd1), .rd2(rd2), .conflict(conflict)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic grants(input string tag, input logic r0, input logic r1, input logic c);
      chk({tag, ".req0_ready"}, 32'(req0_ready), 32'(r0));
      chk({tag, ".req1_ready"}, 32'(req1_ready), 32'(r1));
      chk({tag, ".conflict"},   32'(conflict),   32'(c));
   endtask

   task automatic wstage(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
      chk({tag, ".we3"}, 32'(we3), 32'(w));
      chk({tag, ".a3"},  32'(a3),  32'(a));
      chk({tag, ".wd3"}, wd3, d);
   endtask

   initial begin
      rst = 1'b0; hold = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = 32'h11;
      req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'h22;
      a1 = '0; a2 = '0; rf_rd1 = '0; rf_rd2 = '0;

      // Reset held for two cycles with both requesters valid
      tick(); tick();
      grants("reset", 1'b0, 1'b0, 1'b0);
      wstage("reset", 1'b0, 5'd0, 32'h0);
      rst = 1'b1; #1;
      grants("post_reset", 1'b1, 1'b0, 1'b1);
      tick();
      wstage("post_reset_w0", 1'b1, 5'd9, 32'h11);
      req0_valid = 1'b0; #1;
      grants("post_reset_r1", 1'b0, 1'b1, 1'b0);
      tick();
      wstage("post_reset_w1", 1'b1, 5'd10, 32'h22);

      // Single requester
      req1_valid = 1'b0; req1_addr = 5'd5; req1_data = 32'hDEADBEEF;
      req1_valid = 1'b1; #1;
      grants("single", 1'b0, 1'b1, 1'b0);
      tick();
      req1_valid = 1'b0; a1 = 5'd5; rf_rd1 = 32'h0; a2 = 5'd3; rf_rd2 = 32'h77; #1;
      wstage("single_w", 1'b1, 5'd5, 32'hDEADBEEF);
      chk("single_fwd_rd1", rd1, 32'hDEADBEEF);
      chk("single_nofwd_rd2", rd2, 32'h77);

      // Contention: ptr points at req0
      req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h101;
      req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h303; #1;
      grants("cont0", 1'b1, 1'b0, 1'b1);
      tick();
      req0_addr = 5'd2; req0_data = 32'h202; #1;
      wstage("cont0_w", 1'b1, 5'd1, 32'h101);
      grants("cont1", 1'b0, 1'b1, 1'b1);
      tick();
      req1_addr = 5'd4; req1_data = 32'h404; #1;
      wstage("cont1_w", 1'b1, 5'd3, 32'h303);
      grants("cont2", 1'b1, 1'b0, 1'b1);
      tick();
      req0_valid = 1'b0; #1;
      wstage("cont2_w", 1'b1, 5'd2, 32'h202);
      grants("cont3", 1'b0, 1'b1, 1'b0);
      tick();
      req1_valid = 1'b0; a2 = 5'd4; #1;
      wstage("cont3_w", 1'b1, 5'd4, 32'h404);
      chk("cont3_fwd_rd2", rd2, 32'h404);

      // x0 write accepted but suppressed
      req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h1234; #1;
      grants("x0", 1'b1, 1'b0, 1'b0);
      tick();
      req0_valid = 1'b0; a1 = 5'd0; rf_rd1 = 32'h0; #1;
      wstage("x0_w", 1'b0, 5'd0, 32'h1234);
      chk("x0_rd1", rd1, 32'h0);

      // Hold freezes grants for three cycles
      hold = 1'b1; req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h66;
      for (int i = 0; i < 3; i++) begin
         #1;
         grants("hold", 1'b0, 1'b0, 1'b0);
         tick();
         chk("hold_we3", 32'(we3), 32'h0);
      end
      hold = 1'b0; #1;
      grants("hold_release", 1'b1, 1'b0, 1'b0);
      tick();
      req0_valid = 1'b0; #1;
      wstage("hold_release_w", 1'b1, 5'd6, 32'h66);
      tick();
      wstage("idle_w", 1'b0, 5'd6, 32'h66);

      // Reset discards the in-flight write
      req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hA5A5A5A5; #1;
      grants("rstmid", 1'b0, 1'b1, 1'b0);
      tick();
      a1 = 5'd7; rf_rd1 = 32'h12345678;
      rst = 1'b0; req0_valid = 1'b1; req0_addr = 5'd8; #1;
      wstage("rstmid_inflight", 1'b1, 5'd7, 32'hA5A5A5A5);
      chk("rstmid_fwd_rd1", rd1, 32'hA5A5A5A5);
      grants("rstmid_in_reset", 1'b0, 1'b0, 1'b0);
      tick();
      wstage("rstmid_after", 1'b0, 5'd0, 32'h0);
      chk("rstmid_nofwd_rd1", rd1, 32'h12345678);
      rst = 1'b1; #1;
      grants("rstmid_release", 1'b1, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
